// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - multi-channel PWM with shared programmable-period counter
// Optional macro PWM_DEADTIME_EN adds per-channel dead-band and complementary PWM_N outputs.
module pwm_multi_channel #(
  parameter int WIDTH    = 7,
  parameter int CHANNELS = 4,
  parameter int DEADTIME = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic [WIDTH-1:0]          PERIOD,
  input  logic [CHANNELS*WIDTH-1:0] DUTY,
  output logic [WIDTH-1:0]          CNT,
  output logic                      E,
  output logic [CHANNELS-1:0]       PWM_OUT,
  output logic [CHANNELS-1:0]       PWM_N
);

  if (DEADTIME < 1 || DEADTIME > (2 ** WIDTH) - 1) begin : g_deadtime_range
    $error("DEADTIME out of range");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     per_sh;
  logic [WIDTH-1:0]     duty_sh [CHANNELS];
  logic                 active;
  logic                 wrap;
  logic                 load;
  logic [CHANNELS-1:0]  raw;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (EN)  state_next = RUN;
      RUN:     if (!EN) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Dropping EN in RUN zeroes outputs on the same edge it leaves RUN, and suppresses a wrap load.
  always_comb begin
    active = (state == RUN) && EN;
    wrap   = active && (CNT == per_sh);
    load   = ((state == IDLE) && EN) || wrap;
    raw    = '0;
    for (int i = 0; i < CHANNELS; i++) raw[i] = active && (CNT < duty_sh[i]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      CNT    <= '0;
      E      <= 1'b0;
      per_sh <= '0;
      for (int i = 0; i < CHANNELS; i++) duty_sh[i] <= '0;
    end else begin
      E   <= active && (CNT == '0);
      CNT <= (!active || wrap) ? '0 : CNT + WIDTH'(1);
      if (load) begin
        per_sh <= PERIOD;
        for (int i = 0; i < CHANNELS; i++) duty_sh[i] <= DUTY[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam int DTW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  logic [DTW-1:0]      dt [CHANNELS];
  logic [CHANNELS-1:0] raw_q;

  // dt holds remaining blanked cycles after the transition cycle itself, hence DEADTIME-1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      raw_q   <= '0;
      PWM_OUT <= '0;
      PWM_N   <= '0;
      for (int i = 0; i < CHANNELS; i++) dt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!active) begin
          raw_q[i]   <= 1'b0;
          dt[i]      <= '0;
          PWM_OUT[i] <= 1'b0;
          PWM_N[i]   <= 1'b0;
        end else begin
          raw_q[i] <= raw[i];
          if (raw[i] != raw_q[i]) begin
            dt[i]      <= DTW'(DEADTIME - 1);
            PWM_OUT[i] <= 1'b0;
            PWM_N[i]   <= 1'b0;
          end else if (dt[i] != '0) begin
            dt[i]      <= dt[i] - DTW'(1);
            PWM_OUT[i] <= 1'b0;
            PWM_N[i]   <= 1'b0;
          end else begin
            PWM_OUT[i] <= raw[i];
            PWM_N[i]   <= ~raw[i];
          end
        end
      end
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (RST) PWM_OUT <= '0;
    else     PWM_OUT <= raw;
  end

  assign PWM_N = '0;
`endif

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb/tb_pwm_multi_channel.sv - self-checking bench for pwm_multi_channel
// Honours PWM_DEADTIME_EN to match the DUT build.
module tb_pwm_multi_channel;
  localparam int W  = 7;
  localparam int CH = 4;
  localparam int DT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [W-1:0]  period;
  logic [CH*W-1:0] duty;
  logic [W-1:0]  cnt;
  logic          e;
  logic [CH-1:0] pwm_out;
  logic [CH-1:0] pwm_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_multi_channel #(.WIDTH(W), .CHANNELS(CH), .DEADTIME(DT)) dut (
    .CLK(clk), .RST(rst), .EN(en), .PERIOD(period), .DUTY(duty),
    .CNT(cnt), .E(e), .PWM_OUT(pwm_out), .PWM_N(pwm_n)
  );

  // Reference model: period/duty rules in plain integers, dead-band as "raw stable for DT+1 cycles".
  bit         m_run;
  int         m_cnt, m_per;
  int         m_duty [CH];
  bit         m_e;
  bit [CH-1:0] m_out, m_n;
  bit         hist [CH][DT+1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_tick();
    bit act;
    bit stable;
    bit [CH-1:0] raw;
    if (rst) begin
      m_run = 0; m_cnt = 0; m_per = 0; m_e = 0; m_out = '0; m_n = '0;
      for (int i = 0; i < CH; i++) begin
        m_duty[i] = 0;
        for (int k = 0; k <= DT; k++) hist[i][k] = 0;
      end
      return;
    end
    act = m_run && en;
    for (int i = 0; i < CH; i++) raw[i] = act && (m_cnt < m_duty[i]);
    m_e = act && (m_cnt == 0);
`ifdef PWM_DEADTIME_EN
    for (int i = 0; i < CH; i++) begin
      if (!act) begin
        for (int k = 0; k <= DT; k++) hist[i][k] = 0;
        m_out[i] = 0; m_n[i] = 0;
      end else begin
        for (int k = DT; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = raw[i];
        stable = 1;
        for (int k = 0; k <= DT; k++) if (hist[i][k] != raw[i]) stable = 0;
        m_out[i] = stable && raw[i];
        m_n[i]   = stable && !raw[i];
      end
    end
`else
    m_out = raw;
    m_n   = '0;
`endif
    if (!m_run && en) begin
      m_run = 1; m_cnt = 0; m_per = int'(period);
      for (int i = 0; i < CH; i++) m_duty[i] = int'(duty[i*W +: W]);
    end else if (m_run && !en) begin
      m_run = 0; m_cnt = 0;
    end else if (act) begin
      if (m_cnt == m_per) begin
        m_cnt = 0; m_per = int'(period);
        for (int i = 0; i < CH; i++) m_duty[i] = int'(duty[i*W +: W]);
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    chk("cnt_model", cnt, m_cnt[W-1:0]);
    chk("e_model", e, m_e);
    chk("pwm_out_model", pwm_out, m_out);
    chk("pwm_n_model", pwm_n, m_n);
  endtask

  task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
    duty = {W'(d3), W'(d2), W'(d1), W'(d0)};
  endtask

  task automatic wait_cnt(input int v, input string tag);
    int n = 0;
    step();
    while (cnt != W'(v) && n < 400) begin step(); n++; end
    chk(tag, cnt, v);
  endtask

  int meas_len;
  int meas_hi [CH];
  int meas_nhi [CH];

  task automatic measure(input string tag);
    int n = 0;
    while (!e && n < 400) begin step(); n++; end
    chk({tag, "_e_seen"}, e, 1);
    meas_len = 0;
    for (int i = 0; i < CH; i++) begin meas_hi[i] = 0; meas_nhi[i] = 0; end
    do begin
      for (int i = 0; i < CH; i++) begin
        meas_hi[i]  += int'(pwm_out[i]);
        meas_nhi[i] += int'(pwm_n[i]);
      end
      step();
      meas_len++;
    end while (!e && meas_len < 400);
  endtask

  typedef struct {
    int per;
    int d   [CH];
    int len;
    int hi  [CH];
    int nhi [CH];
  } vec_t;

  vec_t vecs [4];
  int   mx;

  initial begin
`ifdef PWM_DEADTIME_EN
    vecs[0] = '{9,   '{0, 4, 9, 10},  10,  '{0, 2, 7, 10},    '{10, 4, 0, 0}};
    vecs[1] = '{4,   '{1, 2, 5, 0},   5,   '{0, 0, 5, 0},     '{2, 1, 0, 5}};
    vecs[2] = '{0,   '{1, 0, 3, 0},   1,   '{1, 0, 1, 0},     '{0, 1, 0, 1}};
    vecs[3] = '{127, '{127, 64, 0, 1}, 128, '{125, 62, 0, 0}, '{0, 62, 128, 125}};
`else
    vecs[0] = '{9,   '{0, 4, 9, 10},  10,  '{0, 4, 9, 10},    '{0, 0, 0, 0}};
    vecs[1] = '{4,   '{1, 2, 5, 0},   5,   '{1, 2, 5, 0},     '{0, 0, 0, 0}};
    vecs[2] = '{0,   '{1, 0, 3, 0},   1,   '{1, 0, 1, 0},     '{0, 0, 0, 0}};
    vecs[3] = '{127, '{127, 64, 0, 1}, 128, '{127, 64, 0, 1}, '{0, 0, 0, 0}};
`endif

    rst = 1; en = 0; period = '0; duty = '0;
    step(); step();
    chk("reset_cnt", cnt, 0);
    chk("reset_e", e, 0);
    chk("reset_pwm_out", pwm_out, 0);
    chk("reset_pwm_n", pwm_n, 0);
    rst = 0;

    for (int v = 0; v < 4; v++) begin
      en = 0; step();
      period = W'(vecs[v].per);
      set_duty(vecs[v].d[0], vecs[v].d[1], vecs[v].d[2], vecs[v].d[3]);
      en = 1;
      repeat (2 * vecs[v].len + 4) step();
      measure("vec");
      chk($sformatf("vec%0d_len", v), meas_len, vecs[v].len);
      for (int i = 0; i < CH; i++) begin
        chk($sformatf("vec%0d_hi%0d", v, i), meas_hi[i], vecs[v].hi[i]);
        chk($sformatf("vec%0d_nhi%0d", v, i), meas_nhi[i], vecs[v].nhi[i]);
      end
    end

    // EN drop mid-period, then restart.
    en = 0; step();
    period = 7'd9; set_duty(0, 4, 9, 10); en = 1;
    repeat (25) step();
    wait_cnt(5, "en_drop_reach5");
    en = 0; step();
    chk("en_drop_cnt", cnt, 0);
    chk("en_drop_e", e, 0);
    chk("en_drop_out", pwm_out, 0);
    chk("en_drop_n", pwm_n, 0);
    en = 1; step();
    chk("restart_e0", e, 0);
    step();
    chk("restart_e1", e, 1);
`ifdef PWM_DEADTIME_EN
    chk("restart_ch1", pwm_out[1], 0);
`else
    chk("restart_ch1", pwm_out[1], 1);
`endif

    // Mid-period input changes only take effect at the next wrap.
    wait_cnt(2, "mid_reach2");
    set_duty(0, 7, 9, 10);
    wait_cnt(3, "mid_reach3");
    period = 7'd4;
    mx = 3;
    for (int n = 0; n < 50 && cnt != 0; n++) begin
      step();
      if (int'(cnt) > mx) mx = int'(cnt);
    end
    chk("mid_cur_max_cnt", mx, 9);
    step();
    chk("mid_new_e", e, 1);
    measure("mid");
    chk("mid_new_len", meas_len, 5);
`ifdef PWM_DEADTIME_EN
    chk("mid_new_ch1_hi", meas_hi[1], 3);
`else
    chk("mid_new_ch1_hi", meas_hi[1], 5);
`endif

    // Reset held mid-run with EN low.
    rst = 1; en = 0; step();
    chk("rst_run_cnt", cnt, 0);
    chk("rst_run_e", e, 0);
    chk("rst_run_out", pwm_out, 0);
    chk("rst_run_n", pwm_n, 0);
    step(); step();
    rst = 0;
    repeat (3) step();
    chk("rst_idle_cnt", cnt, 0);
    chk("rst_idle_out", pwm_out, 0);

    // Randomized run against the model.
    en = 1;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) en = ~en;
      else if (!en && $urandom_range(0, 3) == 0) en = 1;
      if ($urandom_range(0, 14) == 0) period = W'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0)
        set_duty($urandom_range(0, 14), $urandom_range(0, 14),
                 $urandom_range(0, 14), $urandom_range(0, 14));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
